// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// One full-adder bit per clock; start/done handshake toward a controlling FSM.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between the controlling FSM (master) and the serial adder (slave).
// start is only honoured while busy and done are both low.
interface serial_adder_if import serial_adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Combinational full adder built from two half-adder cells and an OR.
// Zero latency; no flow control.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g0;
  logic g1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(p), .c(g0));
  half_adder u_ha1 (.a(p),  .b(ci), .s(s), .c(g1));

  assign co = g0 | g1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit pair per clock, LSB first, through a single full adder.
// done pulses WIDTH edges after accept; start is ignored (not queued) outside IDLE.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] s_cat;

  full_adder_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_next)
  );

  // The newest sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  // Only WIDTH-1 bits are stored: the last bit goes straight into sum on the final edge.
  assign s_cat = {s_bit, s_sr_q};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_cat[WIDTH-1:1];
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = s_cat;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=13 against an arithmetic reference model.
// Directed handshake/reset scenarios followed by a randomized operand sweep.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(13)) if13 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13));

  int          sel_w = 8;
  logic        drv_start = 1'b0;
  logic [63:0] drv_a = '0;
  logic [63:0] drv_b = '0;
  logic        drv_cin = 1'b0;

  assign if8.start  = drv_start && (sel_w == 8);
  assign if8.a      = drv_a[7:0];
  assign if8.b      = drv_b[7:0];
  assign if8.cin    = drv_cin;
  assign if13.start = drv_start && (sel_w == 13);
  assign if13.a     = drv_a[12:0];
  assign if13.b     = drv_b[12:0];
  assign if13.cin   = drv_cin;

  logic        o_busy, o_done, o_cout;
  logic [63:0] o_sum;

  always_comb begin
    o_busy = if8.busy;
    o_done = if8.done;
    o_cout = if8.cout;
    o_sum  = 64'(if8.sum);
    if (sel_w == 13) begin
      o_busy = if13.busy;
      o_done = if13.done;
      o_cout = if13.cout;
      o_sum  = 64'(if13.sum);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {cout,sum} is simply the (w+1)-bit integer sum of the masked operands and carry-in.
  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    logic [64:0] m;
    m = (65'd1 << w) - 65'd1;
    return ((65'(a) & m) + (65'(b) & m) + 65'(c)) & ((m << 1) | 65'd1);
  endfunction

  function automatic logic [64:0] obs();
    return (65'(o_cout) << sel_w) | 65'(o_sum);
  endfunction

  task automatic do_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic c,
                        input string tag);
    logic [64:0] exp;
    logic [64:0] prev;
    int lat;
    int busy_cnt;
    bit seen;
    sel_w = w;
    exp = ref_add(w, a, b, c);
    @(negedge clk);
    prev = obs();
    drv_a = a;
    drv_b = b;
    drv_cin = c;
    drv_start = 1'b1;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    drv_a = {$urandom, $urandom};
    drv_b = {$urandom, $urandom};
    drv_cin = 1'($urandom_range(1, 0));
    @(negedge clk);
    chk({tag, " busy"}, 65'(o_busy), 65'd1);
    chk({tag, " hold"}, obs(), prev);
    seen = 0;
    lat = 0;
    busy_cnt = 0;
    while (!seen && lat < w + 4) begin
      if (o_done) begin
        seen = 1;
      end else begin
        if (o_busy) busy_cnt++;
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    chk({tag, " latency"}, 65'(lat), 65'(w));
    chk({tag, " busy_cycles"}, 65'(busy_cnt), 65'(w));
    chk({tag, " result"}, obs(), exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse"}, 65'(o_done), 65'd0);
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    logic [63:0] ones;

    #12;
    sel_w = 8;
    chk("rst8 busy", 65'(o_busy), 65'd0);
    chk("rst8 done", 65'(o_done), 65'd0);
    chk("rst8 result", obs(), 65'd0);
    sel_w = 13;
    chk("rst13 busy", 65'(o_busy), 65'd0);
    chk("rst13 result", obs(), 65'd0);
    sel_w = 8;
    @(negedge clk);
    rst = 1'b0;

    do_add(8, 64'h5A, 64'h3C, 1'b0, "t1");
    do_add(8, 64'hFF, 64'h01, 1'b0, "t2a");
    do_add(8, 64'hFF, 64'hFF, 1'b1, "t2b");

    // Start held high across two complete operations.
    sel_w = 8;
    @(negedge clk);
    drv_a = 64'h10;
    drv_b = 64'h20;
    drv_cin = 1'b0;
    drv_start = 1'b1;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    for (int e = 0; e < 23; e++) begin
      @(posedge clk);
      if (e == 19) begin
        #1;
        drv_start = 1'b0;
      end
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (d1 < 0) d1 = e;
        else d2 = e;
        chk("t3 result", obs(), 65'h30);
      end
    end
    drv_start = 1'b0;
    chk("t3 done_count", 65'(ndone), 65'd2);
    chk("t3 first_done", 65'(d1), 65'd8);
    chk("t3 second_done", 65'(d2), 65'd18);
    chk("t3 idle", 65'(o_busy), 65'd0);

    // A request raised mid-RUN must be dropped.
    @(negedge clk);
    drv_a = 64'h01;
    drv_b = 64'h01;
    drv_start = 1'b1;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drv_start = 1'b1;
    drv_a = 64'hAA;
    drv_b = 64'h55;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (o_done) begin
        ndone++;
        chk("t4 result", obs(), 65'h02);
        drv_start = 1'b0;
      end
      @(posedge clk);
    end
    drv_start = 1'b0;
    @(negedge clk);
    chk("t4 done_count", 65'(ndone), 65'd1);
    chk("t4 idle", 65'(o_busy), 65'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    drv_a = 64'hF0;
    drv_b = 64'h0F;
    drv_start = 1'b1;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5 busy", 65'(o_busy), 65'd0);
    chk("t5 done", 65'(o_done), 65'd0);
    chk("t5 result", obs(), 65'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("t5 no_done", 65'(ndone), 65'd0);
    do_add(8, 64'h0F, 64'h01, 1'b0, "t5 post");

    // Corners then random operands at both widths.
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 8 : 13;
      ones = (64'd1 << w) - 64'd1;
      do_add(w, 64'd0, 64'd0, 1'b0, "corner zero");
      do_add(w, 64'd0, 64'd0, 1'b1, "corner zero_cin");
      do_add(w, ones, ones, 1'b0, "corner ones");
      do_add(w, ones, ones, 1'b1, "corner ones_cin");
      do_add(w, ones, 64'd0, 1'b1, "corner ripple");
      for (int i = 0; i < 550; i++) begin
        do_add(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder, the sequential consumer stage built around the team's half-adder cell.
- Two half-adders plus an OR form a full adder; a carry flip-flop is fed back through it, so one operand bit pair is processed per clock, LSB first.
- Trades WIDTH cycles of latency for a single-bit datapath.
- Used where wide adds are infrequent and area matters; start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accept.
- b  input  WIDTH  operand B, captured on accept.
- cin  input  1  carry-in, captured on accept.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result, held until the next done.
- cout  output  1  registered carry-out, held with sum.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, sum=0, cout=0, operand shift regs=0, carry flop=0, bit counter=0.
- States: IDLE, RUN, DONE.
- Accept in IDLE: when start=1 at a clk edge:
  - load a and b into shift regs A_sr/B_sr;
  - carry flop <= cin;
  - counter <= 0;
  - go to RUN.
- RUN, each cycle:
  - s_bit = A_sr[0]^B_sr[0]^carry.
  - c_next = (A_sr[0]&B_sr[0]) | ((A_sr[0]^B_sr[0])&carry), computed via two half-adder stages plus OR.
  - A_sr and B_sr shift right by 1.
  - s_bit shifts into the MSB of internal S_sr, so after WIDTH shifts bit 0 sits at LSB.
  - carry <= c_next; counter++.
- Leaving RUN: when counter==WIDTH-1 at the edge, the final bit is processed and state goes to DONE. RUN therefore lasts exactly WIDTH cycles.
- Entering DONE: sum <= S_sr final value and cout <= final carry, both registered on that same edge. done=1 for exactly the DONE cycle.
- DONE always returns to IDLE on the next edge.
- Latency: accept edge at cycle 0 → done high in cycle WIDTH+1 → next start can be accepted at edge WIDTH+2.
- start while in RUN or DONE is ignored; it is neither queued nor an error.
- a, b, cin may change freely after the accept edge without affecting the result.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state.
- sum/cout change only on entry to DONE; they are stable in IDLE and RUN.
- Overflow: the result is the modulo-2^WIDTH sum, with the (WIDTH+1)th bit on cout.
- Reset mid-RUN: immediate abort, all state cleared, sum/cout forced to 0, no done pulse.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package serial_adder_pkg:
  - state typedef enum {IDLE, RUN, DONE}, 2-bit encoding;
  - default WIDTH localparam.
- One sub-module, full_adder_bit:
  - two half-adder instances plus OR;
  - ports a, b, ci, s, co;
  - purely combinational.
- Top-level holds the FSM, shift registers, carry flop and counter.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → busy for 8 cycles; done in cycle 9 after accept; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. Start held high continuously, a=0x10, b=0x20 (held constant, so both operations compute the same result):
   - done pulses at cycle 9, then the next accept happens at cycle 10;
   - second done at cycle 19; no extra accepts in between;
   - sum=0x30 each time.
4. Accept a=0x01, b=0x01; at RUN cycle 3 drive start=1 with a=0xAA, b=0x55 → the new request is ignored; result is sum=0x02, cout=0, done once.
5. Reset asserted asynchronously (between edges) during RUN cycle 4 → outputs go to 0 immediately, no done. After release, a new add of 0x0F+0x01 gives sum=0x10.
6. Random sweep, WIDTH=8 and WIDTH=13, ≥1000 operands including all-zero/all-one corners → {cout,sum} equals a+b+cin; latency is always WIDTH+1 cycles from accept to done.
